// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; the sub signal exists only
// when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per clock, LSD first, latency WIDTH/DIGIT cycles.
// Optional subtract mode under SERIAL_ADDER_SUB_EN; results held until out_ready.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             vld_q, vld_d, busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] b_eff;
  logic             init_carry;
  logic             accept;

  // In subtract mode B is stored pre-inverted, so RUN is identical for both modes.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff      = bus.sub ? ~bus.b : bus.b;
  assign init_carry = bus.sub | bus.cin;
`else
  assign b_eff      = bus.b;
  assign init_carry = bus.cin;
`endif

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

  assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = b_eff;
          carry_d = init_carry;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the top; after NSLICE shifts slice 0 sits at bit 0.
        sum_d   = WIDTH'({slice[DIGIT-1:0], sum_q} >> DIGIT);
        carry_d = slice[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = slice[DIGIT];
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (slice[DIGIT-1] != a_q[DIGIT-1]);
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=16, DIGIT=4) with directed vectors.
module tb_serial_adder;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sb;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;
  vec_t exp_q[$];
  vec_t e;
  vec_t add_v[5];
  vec_t bp_v, bp2_v, rst_v;

  serial_adder_if #(.WIDTH(16)) bus();

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic send(input vec_t v, input bit push);
    @(negedge clk);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub      = v.sb;
`endif
    bus.in_valid = 1'b1;
    if (push) exp_q.push_back(v);
    for (int k = 0; k < 50 && !bus.in_ready; k++) @(negedge clk);
    if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 1);
    check("in_ready_in_run", 32'(bus.in_ready), 0);
  endtask

  task automatic wait_done(output int l);
    l = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        l = k;
        break;
      end
    end
  endtask

  // Monitor: one pop per output handshake, checked against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("pending_expectations", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    add_v = '{
      '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0}
    };
    bp_v  = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
    bp2_v = '{16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0};
    rst_v = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_sum", 32'(bus.sum), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 1);

    for (int i = 0; i < 5; i++) begin
      send(add_v[i], 1'b1);
      wait_done(lat);
      check("latency", 32'(lat), 4);
    end
    repeat (2) @(negedge clk);

    // Back-pressure: outputs frozen while inputs wiggle.
    bus.out_ready = 1'b0;
    send(bp_v, 1'b1);
    wait_done(lat);
    check("bp_latency", 32'(lat), 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.in_valid = i[0];
      check("bp_sum_held", 32'(bus.sum), 32'h3333);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.a         = bp2_v.a;
    bus.b         = bp2_v.b;
    bus.cin       = bp2_v.cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(bp2_v);
    @(posedge clk);
    #1;
    check("bp_in_ready_after_hs", 32'(bus.in_ready), 1);
    check("bp_busy_after_hs", 32'(bus.busy), 0);
    check("bp_out_valid_after_hs", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_next_accepted", 32'(bus.busy), 1);
    wait_done(lat);
    check("bp2_latency", 32'(lat), 4);
    repeat (2) @(negedge clk);

    // Reset in the second RUN cycle discards the operation.
    send(rst_v, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", 32'(bus.out_valid), 0);
    check("midrun_sum", 32'(bus.sum), 0);
    check("midrun_busy", 32'(bus.busy), 0);
    check("midrun_in_ready", 32'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 1);
    check("release_busy", 32'(bus.busy), 0);
    repeat (8) @(negedge clk);
    check("no_stale_result", 32'(bus.out_valid), 0);

`ifdef SERIAL_ADDER_SUB_EN
    send('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0}, 1'b1);
    wait_done(lat);
    check("sub_latency", 32'(lat), 4);
    send('{16'h0009, 16'h0002, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0}, 1'b1);
    wait_done(lat);
    check("sub2_latency", 32'(lat), 4);
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
